// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit, the data memory and its bench.
package mem_pkg;

   localparam logic [31:0] MEM_BASE_ADDR  = 32'h8002_0000;
   localparam int unsigned MEM_SIZE_BYTES = 256;

   // Encoding of the memory read_write pin
   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } mau_state_t;

   // Range and alignment check. Byte accesses are range-checked as four bytes wide because a
   // byte store also clears the following three locations. The sum is kept in 33 bits so an
   // offset near 2^32 cannot wrap back into range.
   function automatic logic mau_req_error(input logic [31:0] addr,
                                          input logic        is_byte,
                                          input logic [31:0] base,
                                          input int unsigned bytes);
      logic [31:0] off;
      logic [32:0] top;
      logic        range_err;
      logic        align_err;
      off       = addr - base;
      top       = {1'b0, off} + 33'd3;
      range_err = (top >= 33'(bytes));
      align_err = !is_byte && (addr[1:0] != 2'b00);
      return range_err || align_err;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Load result formatting: word pass-through, or the low byte sign/zero-extended.
module load_extend (
   input  logic [31:0] data_i,
   input  logic        is_byte_i,
   input  logic        is_signed_i,
   output logic [31:0] data_o
);

   // Select word or extended byte
   always_comb begin
      data_o = data_i;
      if (is_byte_i) begin
         if (is_signed_i) begin
            data_o = {{24{data_i[7]}}, data_i[7:0]};
         end else begin
            data_o = {24'h00_0000, data_i[7:0]};
         end
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, checked, issued as a single memory access.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR,
   parameter int unsigned MEM_BYTES = MEM_SIZE_BYTES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_byte,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        mem_read_write,
   output logic        mem_enable,
   output logic        mem_isByte
);

   mau_state_t  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic        byte_q, byte_d;
   logic        signed_q, signed_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic        req_err;
   logic [31:0] load_data;

   assign req_err = mau_req_error(req_addr, req_byte, BASE_ADDR, MEM_BYTES);

   load_extend u_load_extend (
      .data_i     (mem_data_out),
      .is_byte_i  (byte_q),
      .is_signed_i(signed_q),
      .data_o     (load_data)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = req_err ? StResp : StIssue;
            end
         end
         StIssue: state_d = StResp;
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Request latch and response capture
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         byte_q   <= 1'b0;
         signed_q <= 1'b0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         byte_q   <= byte_d;
         signed_q <= signed_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

   // Latch on acceptance; capture load data on the closing edge of ISSUE
   always_comb begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      byte_d   = byte_q;
      signed_d = signed_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      if (state_q == StIdle && req_valid) begin
         addr_d   = req_addr;
         wdata_d  = req_wdata;
         write_d  = req_write;
         byte_d   = req_byte;
         signed_d = req_signed;
         rdata_d  = '0;
         error_d  = req_err;
      end else if (state_q == StIssue) begin
         rdata_d = write_q ? 32'h0000_0000 : load_data;
         error_d = 1'b0;
      end
   end

   // Output decode from registered state only; reset forces the idle values
   always_comb begin
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_error     = 1'b0;
      mem_enable     = 1'b0;
      mem_read_write = MEM_READ;
      mem_isByte     = 1'b0;
      mem_address    = '0;
      mem_data_in    = '0;
      if (reset) begin
         req_ready = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: req_ready = 1'b1;
            StIssue: begin
               mem_enable     = 1'b1;
               mem_address    = addr_q;
               mem_isByte     = byte_q;
               mem_read_write = write_q ? MEM_WRITE : MEM_READ;
               if (write_q) begin
                  // Byte stores travel in the top byte lane of data_in
                  mem_data_in = byte_q ? {wdata_q[7:0], 24'h00_0000} : wdata_q;
               end
            end
            StResp: begin
               resp_valid = 1'b1;
               resp_rdata = rdata_q;
               resp_error = error_q;
            end
            default: req_ready = 1'b0;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the CPU datapath and the `memory` block. It accepts one load or store request at a time over a valid/ready handshake and checks the address for range and alignment. It then drives a single memory access and returns read data or an error over a valid/ready response channel. Loads return word, signed-byte or unsigned-byte results.

## Interface

Parameters:
- `BASE_ADDR`, 32'h80020000, first byte address of the data memory.
- `MEM_BYTES`, 256, number of byte locations in the data memory.

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = word access.
- `req_signed`  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; byte stores use bits [7:0].
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_error`  out  1  request was rejected (range or alignment).
- `mem_address`  out  32  to memory `address`.
- `mem_data_in`  out  32  to memory `data_in`.
- `mem_data_out`  in  32  from memory `data_out`.
- `mem_read_write`  out  1  to memory `read_write`; 1 = read, 0 = write.
- `mem_enable`  out  1  to memory `enable`.
- `mem_isByte`  out  1  to memory `isByte`.

## Operation

States: IDLE, ISSUE, RESP.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch the request and compute `off = req_addr - BASE_ADDR` (32-bit unsigned).
  - The request is in error if `off + 3 >= MEM_BYTES` or if it is a word access with `req_addr[1:0] != 0`. The range check uses `off + 3` for byte accesses too, because the memory writes four bytes on a byte store. The sum is computed in 33 bits so wrap-around cannot pass the check.
  - On error: go to RESP with `resp_error`=1 and no memory access.
  - Otherwise: go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `mem_enable`=1, `mem_address`=latched address, `mem_isByte`=`req_byte`, `mem_read_write`=~`req_write`.
  - Word store: `mem_data_in`=`req_wdata`.
  - Byte store: `mem_data_in`={`req_wdata[7:0]`, 24'h0}.
  - On the closing edge, capture `mem_data_out` for loads and go to RESP.
  - Load result:
    - word: `mem_data_out`.
    - signed byte: sign-extend `mem_data_out[7:0]`.
    - unsigned byte: zero-extend `mem_data_out[7:0]`.
  - The result is 0 for stores.
- **RESP**
  - `resp_valid`=1 with `resp_rdata` and `resp_error` held stable.
  - When `resp_ready`=1, go to IDLE.
  - `req_ready`=0, so no request is accepted in the same cycle.

Memory-side rules:
- A byte store also writes 8'h00 to the next three locations. This is the defined behaviour of the memory and is not compensated for here.
- In every state other than ISSUE, the unit drives `mem_enable`=0, `mem_read_write`=1, `mem_isByte`=0, `mem_address`=0 and `mem_data_in`=0.

Reset:
- The unit enters IDLE.
- Output values while `reset` is asserted: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `mem_enable`=0, `mem_read_write`=1, `mem_isByte`=0, `mem_address`=0, `mem_data_in`=0.
- Reset during ISSUE: the in-flight store may already have committed at that edge. No response is produced.
- Reset during RESP: the pending response is dropped.

## Timing

- All outputs are decoded from registered state and latched request fields. There is no combinational path from any `req_*` input to any `mem_*` output.
- Request accepted at edge N:
  - ISSUE occupies cycle N..N+1.
  - `resp_valid` rises after edge N+1.
  - Best-case latency from acceptance to response is 2 edges.
- Error path: `resp_valid` rises after edge N, for 1 edge of latency.
- Memory read data is updated on the memory's falling edge inside the ISSUE cycle and is sampled on the following rising edge.
- Throughput is at most one request per 3 cycles: IDLE, ISSUE, RESP.
- `resp_valid` stays high until a cycle with `resp_ready`=1 completes. Back-pressure is unbounded.

## Structure

- Shared package `mem_pkg`:
  - state enum `mau_state_t` (IDLE, ISSUE, RESP).
  - constants `MEM_BASE_ADDR` and `MEM_SIZE_BYTES`, also used by `memory` and the testbench.
  - the read/write encoding `MEM_READ`=1 and `MEM_WRITE`=0.
- One natural sub-module, `load_extend`: combinational byte select with sign/zero extension, reused later by the writeback stage.

## Test plan

1. **Word store then word load.** Store to 32'h80020010 with 32'hDEADBEEF, then load from 32'h80020010 → load response has `resp_rdata`=32'hDEADBEEF and `resp_error`=0. The store cycle shows `mem_enable`=1 and `mem_read_write`=0 for exactly one cycle.
2. **Byte store then byte loads.** Byte store 8'hF0 to 32'h80020021, then:
   - signed byte load → 32'hFFFFFFF0.
   - unsigned byte load → 32'h000000F0.
   - word load from 32'h80020020 → `resp_rdata[23:0]`=24'hF00000.
3. **Errors.**
   - word access at 32'h80020002 → `resp_error`=1, with `mem_enable` never asserted.
   - any access at 32'h80020000 + `MEM_BYTES` - 2 → `resp_error`=1.
   - any access at 32'h7FFFFFFF → `resp_error`=1.
4. **Back-pressure.** Hold `resp_ready`=0 for 5 cycles after a load → `resp_valid` and `resp_rdata` stay stable and `req_ready` stays 0. The response is accepted on the first cycle with `resp_ready`=1.
5. **Reset mid-operation.** Assert `reset` during ISSUE of a load → after the edge, all outputs are at their reset values and no `resp_valid` pulse occurs. The next request completes normally.
6. **Back-to-back requests.** Hold `req_valid` high continuously across 4 requests → exactly 4 responses in order, with one accepted request per 3 cycles.
